// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the 3-stage pipeline sequencer: FSM state encodings
// and the NOP instruction word that the ID->EX datapath mux loads on a bubble.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_ST_BOOT  = 2'd0,
    PC_ST_RUN   = 2'd1,
    PC_ST_FLUSH = 2'd2
  } pc_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned BOOT_CNT_W = 4;

endpackage

// File: rtl/perf_counters.sv
// Cycle and retired-instruction counters read through MMIO; a clear pulse
// zeroes both and takes priority over any increment in the same cycle.
module perf_counters #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cyc_inc,
  input  logic             ret_inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] cycle_d;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  // Next-count selection; both counters wrap naturally at 2^CNT_W.
  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (clear) begin
      cycle_d   = '0;
      instret_d = '0;
    end else begin
      if (cyc_inc) begin
        cycle_d = cycle_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cycle_d = cycle_q;
      end
      if (ret_inc) begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_d = instret_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer for the 3-stage core: boot hold, redirect bubbles,
// global stall freeze, stage valid bits and the performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_sel_ex,
  input  logic             stall_req,
  input  logic             cnt_clear,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             nop_sel_ex,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);

  pc_state_e             state_q;
  pc_state_e             state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q;
  logic [BOOT_CNT_W-1:0] boot_cnt_d;
  logic                  ex_valid_q;
  logic                  mem_valid_q;
  logic                  cyc_inc_s;
  logic                  ret_inc_s;

  // Next state and pipeline controls; stall overrides everything outside BOOT.
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    nop_sel_ex  = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    cyc_inc_s   = 1'b0;
    case (state_q)
      PC_ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = PC_ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end
      PC_ST_RUN: begin
        cyc_inc_s = 1'b1;
        if (stall_req) begin
          pc_en      = 1'b0;
          id_ex_en   = 1'b0;
          ex_mem_en  = 1'b0;
          nop_sel_ex = 1'b0;
        end else begin
          pc_en      = 1'b1;
          nop_sel_ex = 1'b0;
          if (ex_valid_q && pc_sel_ex) begin
            pc_redirect = 1'b1;
            nop_sel_ex  = 1'b1;
            state_d     = PC_ST_FLUSH;
          end else begin
            state_d = PC_ST_RUN;
          end
        end
      end
      PC_ST_FLUSH: begin
        cyc_inc_s = 1'b1;
        if (stall_req) begin
          pc_en      = 1'b0;
          id_ex_en   = 1'b0;
          ex_mem_en  = 1'b0;
          nop_sel_ex = 1'b0;
        end else begin
          pc_en   = 1'b1;
          state_d = PC_ST_RUN;
        end
      end
      default: begin
        state_d    = PC_ST_BOOT;
        boot_cnt_d = '0;
      end
    endcase
  end

  // FSM state and boot hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PC_ST_BOOT;
      boot_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  // Stage valid bits follow the pipeline register enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      if (id_ex_en) begin
        ex_valid_q <= !nop_sel_ex;
      end
      if (ex_mem_en) begin
        mem_valid_q <= ex_valid_q;
      end
    end
  end

  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign ret_inc_s = mem_valid_q & ex_mem_en;

  perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf_counters (
    .clk         (clk),
    .rst_n       (rst_n),
    .cyc_inc     (cyc_inc_s),
    .ret_inc     (ret_inc_s),
    .clear       (cnt_clear),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; a second small instance
// (BOOT_CYCLES=1, CNT_W=4) exercises the minimum boot hold and counter wrap.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pc_sel_ex;
  logic        stall_req;
  logic        cnt_clear;
  logic        pc_en;
  logic        pc_redirect;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        nop_sel_ex;
  logic        ex_valid;
  logic        mem_valid;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  logic        s_pc_sel_ex;
  logic        s_stall_req;
  logic        s_cnt_clear;
  logic        s_pc_en;
  logic        s_pc_redirect;
  logic        s_id_ex_en;
  logic        s_ex_mem_en;
  logic        s_nop_sel_ex;
  logic        s_ex_valid;
  logic        s_mem_valid;
  logic [3:0]  s_cycle_cnt;
  logic [3:0]  s_instret_cnt;

  int tests_run;
  int tests_failed;

  pipeline_ctrl #(.BOOT_CYCLES(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .pc_sel_ex(pc_sel_ex), .stall_req(stall_req),
    .cnt_clear(cnt_clear), .pc_en(pc_en), .pc_redirect(pc_redirect),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .nop_sel_ex(nop_sel_ex),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  pipeline_ctrl #(.BOOT_CYCLES(1), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .pc_sel_ex(s_pc_sel_ex), .stall_req(s_stall_req),
    .cnt_clear(s_cnt_clear), .pc_en(s_pc_en), .pc_redirect(s_pc_redirect),
    .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en), .nop_sel_ex(s_nop_sel_ex),
    .ex_valid(s_ex_valid), .mem_valid(s_mem_valid), .cycle_cnt(s_cycle_cnt),
    .instret_cnt(s_instret_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Leaves the bench at the negedge where reset is released: cycle 0.
  task automatic do_reset();
    rst_n     = 1'b0;
    pc_sel_ex = 1'b0;
    stall_req = 1'b0;
    cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc_en, pc_redirect, nop_sel_ex, id_ex_en, ex_mem_en, ex_valid, mem_valid} !== 7'b0011100) begin
      $display("FAIL reset_ctrl: got %b exp %b", {pc_en, pc_redirect, nop_sel_ex, id_ex_en, ex_mem_en, ex_valid, mem_valid}, 7'b0011100);
      tests_failed++;
    end
    tests_run++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d exp 0/0", cycle_cnt, instret_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_boot();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      tests_run++;
      if (pc_en !== (c >= 2) || nop_sel_ex !== (c < 2) || pc_redirect !== 1'b0) begin
        $display("FAIL boot_ctrl c%0d: got pc_en=%b nop=%b redir=%b exp pc_en=%b nop=%b redir=0", c, pc_en, nop_sel_ex, pc_redirect, c >= 2, c < 2);
        tests_failed++;
      end
      tests_run++;
      if (ex_valid !== (c >= 3) || mem_valid !== (c >= 4)) begin
        $display("FAIL boot_valid c%0d: got ex=%b mem=%b exp ex=%b mem=%b", c, ex_valid, mem_valid, c >= 3, c >= 4);
        tests_failed++;
      end
      tests_run++;
      if (cycle_cnt !== ((c >= 2) ? 32'(c - 2) : 32'd0) || instret_cnt !== ((c >= 5) ? 32'd1 : 32'd0)) begin
        $display("FAIL boot_cnt c%0d: got cyc=%0d ret=%0d", c, cycle_cnt, instret_cnt);
        tests_failed++;
      end
    end
  endtask

  task automatic test_redirect();
    logic exp_ev;
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      pc_sel_ex = (c == 10);
      #1;
      exp_ev = (c >= 3) && (c != 11) && (c != 12);
      tests_run++;
      if (pc_redirect !== (c == 10) || nop_sel_ex !== ((c < 2) || c == 10 || c == 11) || ex_valid !== exp_ev) begin
        $display("FAIL redirect c%0d: got redir=%b nop=%b ev=%b exp redir=%b nop=%b ev=%b", c, pc_redirect, nop_sel_ex, ex_valid, c == 10, (c < 2) || c == 10 || c == 11, exp_ev);
        tests_failed++;
      end
      if (c >= 12) begin
        tests_run++;
        if (instret_cnt !== ((c <= 14) ? 32'd8 : 32'(c - 6))) begin
          $display("FAIL redirect_instret c%0d: got %0d exp %0d", c, instret_cnt, (c <= 14) ? 8 : c - 6);
          tests_failed++;
        end
      end
    end
    pc_sel_ex = 1'b0;
  endtask

  task automatic test_stall_redirect();
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      pc_sel_ex = (c >= 10) && (c <= 13);
      stall_req = (c >= 10) && (c <= 12);
      #1;
      if (c >= 10 && c <= 12) begin
        tests_run++;
        if ({pc_en, id_ex_en, ex_mem_en, pc_redirect, nop_sel_ex, ex_valid} !== 6'b000001) begin
          $display("FAIL stall_ctrl c%0d: got %b exp %b", c, {pc_en, id_ex_en, ex_mem_en, pc_redirect, nop_sel_ex, ex_valid}, 6'b000001);
          tests_failed++;
        end
      end
      if (c == 10 || c == 13) begin
        tests_run++;
        if (cycle_cnt !== 32'(c - 2) || instret_cnt !== 32'd6) begin
          $display("FAIL stall_cnt c%0d: got cyc=%0d ret=%0d exp cyc=%0d ret=6", c, cycle_cnt, instret_cnt, c - 2);
          tests_failed++;
        end
      end
      if (c >= 13) begin
        tests_run++;
        if (pc_redirect !== (c == 13) || nop_sel_ex !== 1'b1 || pc_en !== 1'b1) begin
          $display("FAIL stall_release c%0d: got redir=%b nop=%b pc_en=%b exp redir=%b nop=1 pc_en=1", c, pc_redirect, nop_sel_ex, pc_en, c == 13);
          tests_failed++;
        end
      end
    end
    pc_sel_ex = 1'b0;
    stall_req = 1'b0;
  endtask

  task automatic test_stall_flush();
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      pc_sel_ex = (c == 10);
      stall_req = (c == 11);
      #1;
      if (c >= 11) begin
        tests_run++;
        if (nop_sel_ex !== (c == 12) || pc_en !== (c != 11) || pc_redirect !== 1'b0) begin
          $display("FAIL stall_flush c%0d: got nop=%b pc_en=%b redir=%b exp nop=%b pc_en=%b redir=0", c, nop_sel_ex, pc_en, pc_redirect, c == 12, c != 11);
          tests_failed++;
        end
        tests_run++;
        if (ex_valid !== (c == 14)) begin
          $display("FAIL stall_flush_ev c%0d: got %b exp %b", c, ex_valid, c == 14);
          tests_failed++;
        end
      end
    end
    stall_req = 1'b0;
  endtask

  task automatic test_counters();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      cnt_clear = (c == 8);
      #1;
      if (c == 8) begin
        tests_run++;
        if (cycle_cnt !== 32'd6 || instret_cnt !== 32'd4 || mem_valid !== 1'b1) begin
          $display("FAIL clear_pre: got cyc=%0d ret=%0d mv=%b exp 6/4/1", cycle_cnt, instret_cnt, mem_valid);
          tests_failed++;
        end
      end
      if (c >= 9) begin
        tests_run++;
        if (cycle_cnt !== 32'(c - 9) || instret_cnt !== 32'(c - 9)) begin
          $display("FAIL clear_post c%0d: got cyc=%0d ret=%0d exp %0d/%0d", c, cycle_cnt, instret_cnt, c - 9, c - 9);
          tests_failed++;
        end
      end
    end
    cnt_clear = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c <= 19; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (c <= 1) begin
        tests_run++;
        if (s_pc_en !== (c == 1)) begin
          $display("FAIL small_boot c%0d: got pc_en=%b exp %b", c, s_pc_en, c == 1);
          tests_failed++;
        end
      end
      if (c == 16 || c == 17) begin
        tests_run++;
        if (s_cycle_cnt !== ((c == 16) ? 4'd15 : 4'd0)) begin
          $display("FAIL cycle_wrap c%0d: got %0d exp %0d", c, s_cycle_cnt, (c == 16) ? 15 : 0);
          tests_failed++;
        end
      end
      if (c == 18 || c == 19) begin
        tests_run++;
        if (s_instret_cnt !== ((c == 18) ? 4'd15 : 4'd0)) begin
          $display("FAIL instret_wrap c%0d: got %0d exp %0d", c, s_instret_cnt, (c == 18) ? 15 : 0);
          tests_failed++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) @(negedge clk);
      pc_sel_ex = (c == 10);
      #1;
    end
    tests_run++;
    if (nop_sel_ex !== 1'b1 || mem_valid !== 1'b1 || cycle_cnt !== 32'd9) begin
      $display("FAIL midrst_pre: got nop=%b mv=%b cyc=%0d exp 1/1/9", nop_sel_ex, mem_valid, cycle_cnt);
      tests_failed++;
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({pc_en, pc_redirect, nop_sel_ex, id_ex_en, ex_mem_en, ex_valid, mem_valid} !== 7'b0011100 || cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      $display("FAIL midrst_async: got ctrl=%b cyc=%0d ret=%0d exp ctrl=0011100 0/0", {pc_en, pc_redirect, nop_sel_ex, id_ex_en, ex_mem_en, ex_valid, mem_valid}, cycle_cnt, instret_cnt);
      tests_failed++;
    end
    pc_sel_ex = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      tests_run++;
      if (pc_en !== (c >= 2) || ex_valid !== (c >= 3)) begin
        $display("FAIL midrst_reboot c%0d: got pc_en=%b ev=%b exp %b/%b", c, pc_en, ex_valid, c >= 2, c >= 3);
        tests_failed++;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    pc_sel_ex    = 1'b0;
    stall_req    = 1'b0;
    cnt_clear    = 1'b0;
    s_pc_sel_ex  = 1'b0;
    s_stall_req  = 1'b0;
    s_cnt_clear  = 1'b0;
    test_reset();
    test_boot();
    test_redirect();
    test_stall_redirect();
    test_stall_flush();
    test_counters();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
